// File: rtl/rca_accumulator_pkg.sv
// Shared types and constants for the packet-summing rca_accumulator block.
package rca_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Wide all-ones pattern; the accumulator slices off its own width.
   localparam int unsigned      SAT_MAX_W    = 64;
   localparam logic [SAT_MAX_W-1:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/rca_accumulator_rcag.sv
// N-bit ripple-carry adder used as the accumulator datapath (RCAG).
module RCAG #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic rc;

   // Carry ripples through a single variable so the chain stays in one process.
   always_comb begin
      rc  = cin;
      sum = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum[i] = in1[i] ^ in2[i] ^ rc;
         rc     = (in1[i] & in2[i]) | (rc & (in1[i] ^ in2[i]));
      end
      cout = rc;
   end

endmodule

// File: rtl/rca_accumulator.sv
// Sums a valid/ready packet of N-bit words through RCAG; result held until accepted.
// Optional saturation of the running sum: define RCA_ACC_SAT_EN.
module rca_accumulator
   import rca_acc_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_carry,
   output logic [CNT_W-1:0] out_count
);

`ifdef RCA_ACC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [N-1:0]     SAT_VAL = SAT_ALL_ONES[N-1:0];

   state_t           state;
   logic [N-1:0]     acc;
   logic [N-1:0]     add_sum;
   logic [N-1:0]     acc_next;
   logic             add_cout;
   logic             carry;
   logic             carry_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             accept;

   RCAG #(.N(N)) u_rcag (
      .in1  (acc),
      .in2  (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      accept     = in_valid && in_ready;
      carry_next = carry | add_cout;
      // Once any beat has overflowed, the sum is pinned for the rest of the packet.
      acc_next   = (SAT_EN && carry_next) ? SAT_VAL : add_sum;
      count_next = (count == CNT_MAX) ? count : count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         carry     <= 1'b0;
         count     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_carry <= 1'b0;
         out_count <= '0;
      end else begin
         case (state)
            IDLE, ACC: begin
               in_ready <= 1'b1;
               if (accept) begin
                  acc   <= acc_next;
                  carry <= carry_next;
                  count <= count_next;
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_sum   <= acc_next;
                     out_carry <= carry_next;
                     out_count <= count_next;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  acc       <= '0;
                  carry     <= 1'b0;
                  count     <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator (N=8, CNT_W=2) against a packet-total model.
module tb_rca_accumulator;

   localparam int unsigned N     = 8;
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_sum;
   logic             out_carry;
   logic [CNT_W-1:0] out_count;

   int passed = 0;
   int total  = 0;

   rca_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   // Packet total from plain integer arithmetic: overflow happened iff the true total reached 256.
   function automatic void model(input int words[$], output logic [7:0] s,
                                 output logic c, output logic [1:0] n);
      int t;
      t = 0;
      foreach (words[i]) t += words[i];
      c = (t >= 256);
`ifdef RCA_ACC_SAT_EN
      s = c ? 8'hFF : 8'(t);
`else
      s = 8'(t % 256);
`endif
      n = (words.size() > 3) ? 2'd3 : 2'(words.size());
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic last);
      int b;
      b        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && b < 50) begin
         step();
         b++;
      end
      total++;
      if (b >= 50) $display("FAIL beat_accept_timeout in_ready=%b required 1", in_ready);
      else passed++;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_pkt(input int words[$], input bit gaps);
      foreach (words[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         send_beat(8'(words[i]), i == words.size() - 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      step(); step();
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
      total++; if (out_sum !== 8'd0) $display("FAIL reset_out_sum got=%0d exp=0", out_sum); else passed++;
      total++; if (out_carry !== 1'b0) $display("FAIL reset_out_carry got=%b exp=0", out_carry); else passed++;
      total++; if (out_count !== 2'd0) $display("FAIL reset_out_count got=%0d exp=0", out_count); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
      rst_n = 1'b1;
      step();
      total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else passed++;
   endtask

   task automatic test_basic();
      int p[$];
      out_ready = 1'b1;
      p = '{3, 4, 5};
      send_pkt(p, 1'b0);
      total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else passed++;
      total++; if (out_sum !== 8'd12) $display("FAIL basic_sum got=%0d exp=12", out_sum); else passed++;
      total++; if (out_carry !== 1'b0) $display("FAIL basic_carry got=%b exp=0", out_carry); else passed++;
      total++; if (out_count !== 2'd3) $display("FAIL basic_count got=%0d exp=3", out_count); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL basic_hold_in_ready got=%b exp=0", in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL basic_after_hs_valid got=%b exp=0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL basic_after_hs_in_ready got=%b exp=1", in_ready); else passed++;
   endtask

   task automatic test_wrap();
      int p[$];
      logic [7:0] es;
`ifdef RCA_ACC_SAT_EN
      es = 8'd255;
`else
      es = 8'd44;
`endif
      out_ready = 1'b1;
      p = '{200, 100};
      send_pkt(p, 1'b0);
      total++; if (out_sum !== es) $display("FAIL wrap_sum got=%0d exp=%0d", out_sum, es); else passed++;
      total++; if (out_carry !== 1'b1) $display("FAIL wrap_carry got=%b exp=1", out_carry); else passed++;
      total++; if (out_count !== 2'd2) $display("FAIL wrap_count got=%0d exp=2", out_count); else passed++;
      step();
   endtask

   task automatic test_backpressure();
      int p[$];
      out_ready = 1'b0;
      p = '{10, 20, 30};
      send_pkt(p, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
         step();
         total++;
         if ({out_valid, out_sum, in_ready} !== {1'b1, 8'd60, 1'b0})
            $display("FAIL bp_hold cyc=%0d got valid=%b sum=%0d in_ready=%b exp valid=1 sum=60 in_ready=0",
                     i, out_valid, out_sum, in_ready);
         else passed++;
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL bp_single_hs_valid got=%b exp=0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_idle_in_ready got=%b exp=1", in_ready); else passed++;
      out_ready = 1'b1;
      p = '{1};
      send_pkt(p, 1'b0);
      total++; if (out_sum !== 8'd1) $display("FAIL bp_next_sum got=%0d exp=1", out_sum); else passed++;
      step();
   endtask

   task automatic test_reset_mid();
      int p[$];
      out_ready = 1'b1;
      send_beat(8'd7, 1'b0);
      send_beat(8'd9, 1'b0);
      rst_n = 1'b0;
      step();
      total++;
      if ({out_valid, out_sum, out_carry, out_count, in_ready} !== '0)
         $display("FAIL midreset_outputs got valid=%b sum=%0d carry=%b count=%0d in_ready=%b exp all 0",
                  out_valid, out_sum, out_carry, out_count, in_ready);
      else passed++;
      rst_n = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL midreset_no_result got=%b exp=0", out_valid); else passed++;
      p = '{1};
      send_pkt(p, 1'b0);
      total++; if (out_sum !== 8'd1) $display("FAIL midreset_next_sum got=%0d exp=1", out_sum); else passed++;
      total++; if (out_count !== 2'd1) $display("FAIL midreset_next_count got=%0d exp=1", out_count); else passed++;
      step();
   endtask

   task automatic test_count_sat();
      int p[$];
      out_ready = 1'b1;
      p = '{1, 1, 1, 1, 1};
      send_pkt(p, 1'b1);
      total++; if (out_count !== 2'd3) $display("FAIL cntsat_count got=%0d exp=3", out_count); else passed++;
      total++; if (out_sum !== 8'd5) $display("FAIL cntsat_sum got=%0d exp=5", out_sum); else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      int p[$];
      out_ready = 1'b1;
      p = '{8'hA5};
      send_pkt(p, 1'b0);
      total++; if (out_sum !== 8'hA5) $display("FAIL b2b_sum got=%0h exp=a5", out_sum); else passed++;
      total++; if (out_count !== 2'd1) $display("FAIL b2b_count got=%0d exp=1", out_count); else passed++;
      in_valid = 1'b1; in_data = 8'd2; in_last = 1'b1;
      total++; if (in_ready !== 1'b0) $display("FAIL b2b_hold_in_ready got=%b exp=0", in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL b2b_after_hs_valid got=%b exp=0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_return got=%b exp=1", in_ready); else passed++;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      total++; if (out_valid !== 1'b1) $display("FAIL b2b_second_valid got=%b exp=1", out_valid); else passed++;
      total++; if (out_sum !== 8'd2) $display("FAIL b2b_second_sum got=%0d exp=2", out_sum); else passed++;
      step();
   endtask

   task automatic test_random();
      int p[$];
      int len;
      int hi;
      logic [7:0] es;
      logic       ec;
      logic [1:0] en;
      for (int k = 0; k < 40; k++) begin
         p.delete();
         len = $urandom_range(1, 6);
         hi  = ($urandom_range(0, 1) == 0) ? 60 : 255;
         for (int j = 0; j < len; j++) p.push_back(int'($urandom_range(0, hi)));
         model(p, es, ec, en);
         out_ready = 1'b0;
         send_pkt(p, 1'b1);
         total++;
         if ({out_valid, out_sum, out_carry, out_count} !== {1'b1, es, ec, en})
            $display("FAIL rand_result pkt=%0d got valid=%b sum=%0d carry=%b count=%0d exp valid=1 sum=%0d carry=%b count=%0d",
                     k, out_valid, out_sum, out_carry, out_count, es, ec, en);
         else passed++;
         repeat ($urandom_range(0, 3)) step();
         total++;
         if ({out_valid, out_sum} !== {1'b1, es})
            $display("FAIL rand_hold pkt=%0d got valid=%b sum=%0d exp valid=1 sum=%0d", k, out_valid, out_sum, es);
         else passed++;
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         total++;
         if (out_valid !== 1'b0) $display("FAIL rand_release pkt=%0d got=%b exp=0", k, out_valid);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      test_count_sat();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
